// File: rtl/full_adder_pkg.sv
// Shared constants and types for the registered ripple-carry adder slice.
package full_adder_pkg;
  localparam int FA_MAX_WIDTH = 32;
  typedef logic [FA_MAX_WIDTH:0] fa_carry_t;
endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder: leaf cell of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder {Cout,Sum} <= A + B + Cin, one-cycle latency.
// Define FULL_ADDER_OVERFLOW_EN to add the registered signed-overflow output Ovf.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin
`ifdef FULL_ADDER_OVERFLOW_EN
  ,
  output logic             Ovf
`endif
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_cell u_cell (
      .a   (A[i]),
      .b   (B[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Cout <= 1'b0;
      Sum  <= '0;
    end else begin
      Cout <= c[WIDTH];
      Sum  <= s;
    end
  end

`ifdef FULL_ADDER_OVERFLOW_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) Ovf <= 1'b0;
    else     Ovf <= c[WIDTH] ^ c[WIDTH-1];
  end
`endif
endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH=1 and WIDTH=8 against an arithmetic reference model.
module tb_full_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       cout1, cout8;
  logic [0:0] sum1;
  logic [7:0] sum8;
`ifdef FULL_ADDER_OVERFLOW_EN
  logic       ovf1, ovf8;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference model state: the value the outputs must currently show
  logic [1:0] e1;
  logic [8:0] e8;
  logic       eo1, eo8;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .Cout(cout1), .Sum(sum1), .A(a1), .B(b1), .Cin(cin1)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .Ovf(ovf1)
`endif
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .Cout(cout8), .Sum(sum8), .A(a8), .B(b8), .Cin(cin8)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .Ovf(ovf8)
`endif
  );

  // signed overflow: does the true signed sum fall outside the w-bit signed range?
  function automatic logic ovf_of(int w, int ua, int ub, int c);
    int sa, sb, t;
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    t  = sa + sb + c;
    return (t > (1 << (w - 1)) - 1) || (t < -(1 << (w - 1)));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e1 = '0; e8 = '0; eo1 = 1'b0; eo8 = 1'b0;
    end else begin
      e1  = 2'(int'(a1) + int'(b1) + int'(cin1));
      e8  = 9'(int'(a8) + int'(b8) + int'(cin8));
      eo1 = ovf_of(1, int'(a1), int'(b1), int'(cin1));
      eo8 = ovf_of(8, int'(a8), int'(b8), int'(cin8));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_w1", {30'd0, cout1, sum1}, {30'd0, e1});
      check("model_w8", {23'd0, cout8, sum8}, {23'd0, e8});
`ifdef FULL_ADDER_OVERFLOW_EN
      check("model_ovf1", {31'd0, ovf1}, {31'd0, eo1});
      check("model_ovf8", {31'd0, ovf8}, {31'd0, eo8});
`endif
    end
  end

  task automatic drive1(input logic [2:0] v);
    {a1, b1, cin1} = v;
  endtask

  logic [2:0] seq [8] = '{3'b101, 3'b001, 3'b010, 3'b000, 3'b111, 3'b110, 3'b011, 3'b100};
  logic [1:0] seq_exp [8] = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b01};

  initial begin
    // async reset mid-cycle with 111 applied
    drive1(3'b111); a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("rst_async_w1", {30'd0, cout1, sum1}, 32'd0);
    check("rst_async_w8", {23'd0, cout8, sum8}, 32'd0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("rst_hold_w1", {30'd0, cout1, sum1}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // exhaustive WIDTH=1, one vector per cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) drive1(seq[i]);
      @(posedge clk); #1;
      check($sformatf("tt_%03b", seq[i]), {30'd0, cout1, sum1}, {30'd0, seq_exp[i]});
    end

    // hold between edges
    @(negedge clk) drive1(3'b111);
    @(posedge clk); #1;
    check("hold_pre", {30'd0, cout1, sum1}, 32'd3);
    #2 drive1(3'b000); #1;
    check("hold_mid", {30'd0, cout1, sum1}, 32'd3);
    @(posedge clk); #1;
    check("hold_post", {30'd0, cout1, sum1}, 32'd0);

    // mid-stream reset pulse spanning one edge, shorter than a cycle
    @(negedge clk) drive1(3'b101);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_edge", {30'd0, cout1, sum1}, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_next", {30'd0, cout1, sum1}, 32'd2);

    // WIDTH=8 boundaries
    @(negedge clk) begin a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; end
    @(posedge clk); #1;
    check("w8_wrap", {23'd0, cout8, sum8}, 32'h100);
    @(negedge clk) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
    @(posedge clk); #1;
    check("w8_allones", {23'd0, cout8, sum8}, 32'h1FF);
    @(negedge clk) begin a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; end
    @(posedge clk); #1;
    check("w8_7f01", {23'd0, cout8, sum8}, 32'h080);
`ifdef FULL_ADDER_OVERFLOW_EN
    check("w8_7f01_ovf", {31'd0, ovf8}, 32'd1);
`endif

    // randomized traffic on both widths
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      drive1(3'($urandom));
    end
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
